grayblast_vga_rx: RTL and testbench
===================================

GRAYBLAST_VGA_RX -- requirements
Module: grayblast_vga_rx

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- H_TOTAL and V_TOTAL are the sums of their four terms (800 and 525).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, pixel clock; the only clock
- rst_n, in, 1, asynchronous active-low reset
- vga_in, in, 8, TinyVGA byte: [0]R1 [1]G1 [2]B1 [3]VSync [4]R0 [5]G0 [6]B0 [7]HSync; both syncs active-low
- clr_err, in, 1, synchronous clear of sticky error flags
- locked, out, 1, receiver aligned to frame timing
- pix_valid, out, 1, active-area pixel on pix_* this cycle
- pix_x, out, 10, pixel column, 0..H_ACTIVE-1
- pix_y, out, 10, pixel row, 0..V_ACTIVE-1
- pix_rgb, out, 6, {R1,R0,G1,G0,B1,B0}
- frame_done, out, 1, one-cycle pulse after the last active pixel of a frame
- frame_sum, out, 16, pixel checksum of the last completed frame
- err_h, out, 1, sticky horizontal timing error
- err_v, out, 1, sticky vertical timing error

Function
REQ-003 SHALL register vga_in once (stage S1); all decoding SHALL operate on S1 and on S1 delayed by one cycle (S2), for edge detection.
REQ-004 An hsync fall is S2.hsync=1 and S1.hsync=0; an hsync rise is the reverse. vsync edges are defined the same way.
REQ-005 hcnt (10 bit) SHALL load 0 on an hsync fall, else increment, saturating at 1023.
REQ-006 err_h SHALL set on any of: hsync rise with hcnt != H_SYNC; hsync fall with hcnt != H_TOTAL-1, except the first fall after SEARCH; hcnt reaching H_TOTAL.
REQ-007 A vsync edge SHALL be latched as pending and resolved at the next hsync fall; an edge in the same cycle as an hsync fall is resolved at that fall.
REQ-008 At each hsync fall, vcnt (10 bit) SHALL load 0 if a fall is pending, else increment, saturating at 1023.
REQ-009 err_v SHALL set when a pending vsync fall resolves with old vcnt != V_TOTAL-1, except the first after SEARCH.
REQ-010 err_v SHALL also set when a pending vsync rise resolves with new vcnt != V_SYNC.
REQ-011 FSM states and transitions:
- SEARCH: leave on the first resolved vsync fall, to ACQUIRE.
- ACQUIRE: on the next resolved vsync fall with no error since entry, go to LOCKED; on any error, go to SEARCH.
- LOCKED: on any new error condition, go to SEARCH.
- locked=1 only in LOCKED.
REQ-012 The active area is hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-013 pix_valid SHALL be 1 only when LOCKED and S1 is in the active area.
REQ-014 pix_x, pix_y and pix_rgb SHALL be registered outputs computed from S1; latency from vga_in to pix_* SHALL be 2 clocks. pix_x = hcnt-(H_SYNC+H_BP) and pix_y = vcnt-(V_SYNC+V_BP).
REQ-015 pix_x, pix_y and pix_rgb SHALL hold their last values when pix_valid=0.
REQ-016 The checksum accumulator SHALL add zero-extended pix_rgb for every pix_valid cycle, modulo 2^16.
REQ-017 In the cycle after the pixel with pix_x=H_ACTIVE-1 and pix_y=V_ACTIVE-1, frame_done SHALL pulse for 1 clock.
REQ-018 In that same cycle, frame_sum SHALL load the accumulator, which SHALL clear.
REQ-019 The accumulator SHALL also clear on entering SEARCH, so no partial frame is ever reported.
REQ-020 clr_err SHALL clear err_h and err_v. A new error in the same cycle as clr_err SHALL win (flag stays set).
REQ-021 Errors SHALL set the sticky flags in every state, including SEARCH.

Reset
REQ-022 While rst_n=0, all of the following SHALL be 0 immediately, independent of clk: outputs, S1/S2 (S1/S2 syncs reset to 1 = inactive), hcnt, vcnt, pending flags, accumulator; the FSM SHALL be in SEARCH.
REQ-023 Reset asserted mid-frame SHALL drop locked and pix_valid without a frame_done pulse. After release, the block SHALL reacquire as from power-up.

Verification
REQ-024 Reset: rst_n=0 with arbitrary vga_in -> all outputs 0, locked=0. Release with idle syncs (vga_in=8'h88) for 1000 clocks -> no errors.
REQ-025 Clean 640x480 stream of 3 frames -> locked rises at the start of frame 2; frames 2 and 3 each give 307200 pix_valid cycles and one frame_done; the first pixel x=0,y=0 appears 2 clocks after it is driven on vga_in.
REQ-026 Constant colour rgb=6'h3F -> frame_sum=16'h5000. Gradient pix_rgb=pix_x[5:0] -> frame_sum equals the model's sum mod 2^16.
REQ-027 Locked, one line with a 95-clock hsync -> err_h=1, locked=0, no frame_done for that frame. Relock follows after two clean frame boundaries. clr_err pulse -> err_h=0.
REQ-028 Locked, one frame with V_TOTAL=524 lines -> err_v=1 at that vsync fall, locked=0. clr_err in the same cycle as a new error -> err_v remains 1.
REQ-029 rst_n pulsed low mid-line in frame 2 -> outputs 0 at once, no frame_done, accumulator cleared. After release, lock is regained and the following frame_sum is correct.

Source files
------------

// File: rtl/grayblast_vga_rx.sv
// TinyVGA receiver: recovers horizontal/vertical timing from the 8-bit
// TinyVGA byte stream, locks onto frame timing, emits active-area pixels
// with coordinates, and reports a per-frame 16-bit pixel checksum.
// Timing violations raise sticky error flags and drop lock.
module grayblast_vga_rx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        clr_err,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        err_h,
  output logic        err_v
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0] H_START_C = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END_C   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_START_C = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END_C   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] X_LAST_C  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST_C  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] CNT_MAX_C = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Input pipeline: S1 holds the whole byte, S2 only the two syncs
  // (colour from S2 is never used, only the sync edges).
  logic [7:0]  s1_reg;
  logic        s2_hs_reg;
  logic        s2_vs_reg;

  logic [9:0]  hcnt_reg, hcnt_next, hcnt_inc;
  logic [9:0]  vcnt_reg, vcnt_next, vcnt_inc;
  logic        pend_fall_reg, pend_fall_next;
  logic        pend_rise_reg, pend_rise_next;
  logic        h_seen_reg, h_seen_next;   // an hsync fall has been seen since SEARCH entry
  state_t      state_reg, state_next;

  logic        pix_valid_reg, pix_valid_next;
  logic [9:0]  pix_x_reg, pix_y_reg;
  logic [5:0]  pix_rgb_reg, rgb_s1;
  logic        frame_done_reg, frame_last;
  logic [15:0] frame_sum_reg, acc_reg, acc_plus;
  logic        err_h_reg, err_v_reg;

  logic        h_fall, h_rise, v_fall, v_rise;
  logic        pend_fall_now, pend_rise_now;
  logic        vfall_res, vrise_res;
  logic        err_h_now, err_v_now, err_now;
  logic        enter_search;
  logic        h_act, v_act;

  // Edge detection on S1 against S2; syncs are active-low.
  assign h_fall = s2_hs_reg & ~s1_reg[7];
  assign h_rise = ~s2_hs_reg & s1_reg[7];
  assign v_fall = s2_vs_reg & ~s1_reg[3];
  assign v_rise = ~s2_vs_reg & s1_reg[3];

  // Byte lane order is {HS,B0,G0,R0,VS,B1,G1,R1}; repack to {R1,R0,G1,G0,B1,B0}.
  assign rgb_s1 = {s1_reg[0], s1_reg[4], s1_reg[1], s1_reg[5], s1_reg[2], s1_reg[6]};

  // hcnt/vcnt_next are the coordinates of the sample currently in S1.
  assign hcnt_inc  = (hcnt_reg == CNT_MAX_C) ? hcnt_reg : hcnt_reg + 10'd1;
  assign hcnt_next = h_fall ? 10'd0 : hcnt_inc;

  // A vsync edge waits for the next hsync fall; a same-cycle edge counts too.
  assign pend_fall_now  = pend_fall_reg | v_fall;
  assign pend_rise_now  = pend_rise_reg | v_rise;
  assign vfall_res      = h_fall & pend_fall_now;
  assign vrise_res      = h_fall & pend_rise_now;
  assign pend_fall_next = h_fall ? 1'b0 : pend_fall_now;
  assign pend_rise_next = h_fall ? 1'b0 : pend_rise_now;

  assign vcnt_inc  = (vcnt_reg == CNT_MAX_C) ? vcnt_reg : vcnt_reg + 10'd1;
  assign vcnt_next = h_fall ? (pend_fall_now ? 10'd0 : vcnt_inc) : vcnt_reg;

  // Line-length and overflow checks only make sense once a line start is known.
  assign err_h_now = (h_rise && (hcnt_next != H_SYNC_C))
                   || (h_fall && h_seen_reg && (hcnt_reg != H_LAST_C))
                   || (h_seen_reg && (hcnt_next == H_TOTAL_C));

  assign err_v_now = (vfall_res && (state_reg != ST_SEARCH) && (vcnt_reg != V_LAST_C))
                   || (vrise_res && (vcnt_next != V_SYNC_C));

  assign err_now = err_h_now | err_v_now;

  // Lock FSM: next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SEARCH:  if (vfall_res && !err_now) state_next = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (err_now)        state_next = ST_SEARCH;
        else if (vfall_res) state_next = ST_LOCKED;
      end
      ST_LOCKED:  if (err_now) state_next = ST_SEARCH;
      default:    state_next = ST_SEARCH;
    endcase
  end

  assign enter_search = (state_next == ST_SEARCH) && (state_reg != ST_SEARCH);
  assign h_seen_next  = enter_search ? 1'b0 : (h_fall ? 1'b1 : h_seen_reg);

  assign h_act = (hcnt_next >= H_START_C) && (hcnt_next < H_END_C);
  assign v_act = (vcnt_next >= V_START_C) && (vcnt_next < V_END_C);
  assign pix_valid_next = (state_next == ST_LOCKED) && h_act && v_act;

  assign frame_last = pix_valid_reg && (pix_x_reg == X_LAST_C) && (pix_y_reg == Y_LAST_C);
  assign acc_plus   = acc_reg + {10'd0, pix_rgb_reg};

  // Input register stage and sync delay for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg    <= 8'h88;
      s2_hs_reg <= 1'b1;
      s2_vs_reg <= 1'b1;
    end else begin
      s1_reg    <= vga_in;
      s2_hs_reg <= s1_reg[7];
      s2_vs_reg <= s1_reg[3];
    end
  end

  // Horizontal/vertical counters and pending vsync edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg      <= '0;
      vcnt_reg      <= '0;
      pend_fall_reg <= 1'b0;
      pend_rise_reg <= 1'b0;
      h_seen_reg    <= 1'b0;
    end else begin
      hcnt_reg      <= hcnt_next;
      vcnt_reg      <= vcnt_next;
      pend_fall_reg <= pend_fall_next;
      pend_rise_reg <= pend_rise_next;
      h_seen_reg    <= h_seen_next;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_SEARCH;
    else        state_reg <= state_next;
  end

  // Pixel outputs: coordinates and colour hold while no pixel is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_reg <= 1'b0;
      pix_x_reg     <= '0;
      pix_y_reg     <= '0;
      pix_rgb_reg   <= '0;
    end else begin
      pix_valid_reg <= pix_valid_next;
      if (pix_valid_next) begin
        pix_x_reg   <= hcnt_next - H_START_C;
        pix_y_reg   <= vcnt_next - V_START_C;
        pix_rgb_reg <= rgb_s1;
      end
    end
  end

  // Frame checksum: a completed frame wins over a simultaneous SEARCH entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      frame_sum_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_last;
      if (frame_last) begin
        frame_sum_reg <= acc_plus;
        acc_reg       <= '0;
      end else if (enter_search) begin
        acc_reg <= '0;
      end else if (pix_valid_reg) begin
        acc_reg <= acc_plus;
      end
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_h_reg <= 1'b0;
      err_v_reg <= 1'b0;
    end else begin
      err_h_reg <= err_h_now | (err_h_reg & ~clr_err);
      err_v_reg <= err_v_now | (err_v_reg & ~clr_err);
    end
  end

  assign locked     = (state_reg == ST_LOCKED);
  assign pix_valid  = pix_valid_reg;
  assign pix_x      = pix_x_reg;
  assign pix_y      = pix_y_reg;
  assign pix_rgb    = pix_rgb_reg;
  assign frame_done = frame_done_reg;
  assign frame_sum  = frame_sum_reg;
  assign err_h      = err_h_reg;
  assign err_v      = err_v_reg;

endmodule

// File: tb/tb_grayblast_vga_rx.sv
// Bench for grayblast_vga_rx using a reduced raster (25x11) so that many
// frames fit in a short run. Frames are generated line by line; the
// expected pixel stream, checksum and frame_done are derived from the
// raster geometry and delayed by the documented 2-clock latency.
module tb_grayblast_vga_rx;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS       = H_SYNC + H_BP;
  localparam int VS       = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic        clr_err = 1'b0;
  logic        locked, pix_valid, frame_done, err_h, err_v;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] frame_sum;

  grayblast_vga_rx #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .clr_err(clr_err),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_sum(frame_sum),
    .err_h(err_h), .err_v(err_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        last;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [5:0]  rgb;
    logic [15:0] sum;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        q [1:3];
  logic [9:0]  hx, hy;
  logic [5:0]  hrgb;
  logic [15:0] efsum;
  int          n_valid_obs = 0, n_valid_exp = 0, n_done_obs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic [5:0] c, input logic hs, input logic vs);
    // c = {R1,R0,G1,G0,B1,B0}
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  // One pixel clock: check outputs for the sample driven two (three) steps
  // earlier, then drive the next sample.
  task automatic step(input logic [7:0] v, input logic clr, input logic do_rst, input exp_t e);
    @(negedge clk);
    if (rst_n == 1'b0) rst_n = 1'b1;
    if (q[2].v) begin
      hx = q[2].x; hy = q[2].y; hrgb = q[2].rgb;
      n_valid_exp++;
    end
    if (pix_valid) n_valid_obs++;
    if (frame_done) n_done_obs++;
    chk("pix_valid", 32'(pix_valid), 32'(q[2].v));
    chk("pix_x", 32'(pix_x), 32'(hx));
    chk("pix_y", 32'(pix_y), 32'(hy));
    chk("pix_rgb", 32'(pix_rgb), 32'(hrgb));
    if (q[3].v && q[3].last) efsum = q[3].sum;
    chk("frame_done", 32'(frame_done), 32'(q[3].v && q[3].last));
    chk("frame_sum", 32'(frame_sum), 32'(efsum));
    vga_in  = v;
    clr_err = clr;
    q[3] = q[2]; q[2] = q[1]; q[1] = e;
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_frame_sum", 32'(frame_sum), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      q[1] = '0; q[2] = '0; q[3] = '0;
      hx = '0; hy = '0; hrgb = '0; efsum = '0;
    end
  endtask

  // mode 0: random colour, 1: constant 6'h3F, 2: gradient rgb = x[5:0]
  task automatic send_frame(input int lines, input int mode, input bit lock,
                            input int bad_line, input int clr_idx, input int rst_idx);
    int   idx = 0;
    int   sum = 0;
    bit   lk = lock;
    bit   act;
    logic hs, vs;
    logic [5:0] c;
    exp_t e;
    for (int l = 0; l < lines; l++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        hs  = (h < ((l == bad_line) ? H_SYNC - 1 : H_SYNC)) ? 1'b0 : 1'b1;
        vs  = (l < V_SYNC) ? 1'b0 : 1'b1;
        act = (h >= HS) && (h < HS + H_ACTIVE) && (l >= VS) && (l < VS + V_ACTIVE);
        c   = 6'($urandom_range(0, 63));
        if (act && mode == 1) c = 6'h3F;
        if (act && mode == 2) c = 6'((h - HS) % 64);
        e      = '0;
        e.v    = lk && act;
        e.x    = 10'(h - HS);
        e.y    = 10'(l - VS);
        e.rgb  = c;
        if (e.v) sum = (sum + int'(c)) % 65536;
        e.sum  = 16'(sum);
        e.last = act && (h - HS == H_ACTIVE - 1) && (l - VS == V_ACTIVE - 1);
        step(pack(c, hs, vs), idx == clr_idx, idx == rst_idx, e);
        if (idx == rst_idx) lk = 1'b0;
        idx++;
      end
    end
  endtask

  initial begin
    q[1] = '0; q[2] = '0; q[3] = '0;
    hx = '0; hy = '0; hrgb = '0; efsum = '0;

    // Reset with arbitrary input
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vga_in = 8'($urandom);
    end
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_pix_valid", 32'(pix_valid), 32'd0);
    chk("reset_pix_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("reset_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("reset_frame", 32'({frame_done, frame_sum}), 32'd0);
    chk("reset_err", 32'({err_h, err_v}), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    vga_in = 8'h88;

    // Idle syncs
    for (int i = 0; i < 1000; i++) step(8'h88, 1'b0, 1'b0, '0);
    chk("idle_err_h", 32'(err_h), 32'd0);
    chk("idle_err_v", 32'(err_v), 32'd0);
    chk("idle_locked", 32'(locked), 32'd0);

    // Clean stream: lock at frame 2
    send_frame(V_TOTAL, 0, 1'b0, -1, -1, -1);
    chk("f1_locked", 32'(locked), 32'd0);
    send_frame(V_TOTAL, 0, 1'b1, -1, -1, -1);
    chk("f2_locked", 32'(locked), 32'd1);
    send_frame(V_TOTAL, 1, 1'b1, -1, -1, -1);
    chk("f3_const_sum", 32'(frame_sum), 32'(H_ACTIVE * V_ACTIVE * 63));
    send_frame(V_TOTAL, 2, 1'b1, -1, -1, -1);
    chk("clean_err", 32'({err_h, err_v}), 32'd0);

    // Short hsync on line 1
    send_frame(V_TOTAL, 0, 1'b0, 1, -1, -1);
    chk("badh_err_h", 32'(err_h), 32'd1);
    chk("badh_locked", 32'(locked), 32'd0);
    send_frame(V_TOTAL, 0, 1'b0, -1, 5, -1);
    chk("clr_err_h", 32'(err_h), 32'd0);
    chk("acq_locked", 32'(locked), 32'd0);
    send_frame(V_TOTAL, 0, 1'b1, -1, -1, -1);
    chk("relock_h", 32'(locked), 32'd1);

    // Short frame, then clear colliding with the detected error
    send_frame(V_TOTAL - 1, 0, 1'b1, -1, -1, -1);
    chk("short_err_v_before", 32'(err_v), 32'd0);
    send_frame(V_TOTAL, 0, 1'b0, -1, 1, -1);
    chk("short_err_v", 32'(err_v), 32'd1);
    chk("short_locked", 32'(locked), 32'd0);
    send_frame(V_TOTAL, 0, 1'b0, -1, 5, -1);
    chk("clr_err_v", 32'(err_v), 32'd0);
    send_frame(V_TOTAL, 0, 1'b1, -1, -1, -1);
    chk("relock_v", 32'(locked), 32'd1);

    // Reset mid-line inside the active area
    send_frame(V_TOTAL, 0, 1'b1, -1, -1, (VS + 1) * H_TOTAL + HS + 5);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_err", 32'({err_h, err_v}), 32'd0);
    send_frame(V_TOTAL, 0, 1'b0, -1, -1, -1);
    send_frame(V_TOTAL, 2, 1'b1, -1, -1, -1);
    chk("rst_relock", 32'(locked), 32'd1);

    for (int i = 0; i < 4; i++) step(8'h88, 1'b0, 1'b0, '0);
    chk("valid_count", 32'(n_valid_obs), 32'(n_valid_exp));
    chk("done_count", 32'(n_done_obs), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
